cbx_counter: RTL and testbench
==============================

// Module: cbx_counter
// PURPOSE
//  Parametrised synchronous loadable up/down counter; successor to the single-bit
//  counter cells. Keeps their chaining convention (active-low count-in ci,
//  active-low carry-out co). Adds width, direction, terminal-count auto-reload
//  and a registered terminal-count strobe. Used for video/bus timing dividers.
// PARAMETERS
//  W       8   counter width in bits (>=2)
//  RST_VAL 0   value of q while xr is low
// PORTS
//  c     in   1  clock; all state changes on rising edge
//  xr    in   1  reset, asynchronous, active-low
//  l     in   1  synchronous load strobe, active-high
//  d     in   W  load data
//  ci    in   1  count enable / carry-in, active-low (0 = count this edge)
//  dn    in   1  direction: 0 = up, 1 = down
//  wrap  in   1  1 = reload rv at terminal count; 0 = free-running modulo 2^W
//  rv    in   W  reload value for wrap mode
//  q     out  W  counter value
//  xq    out  W  ~q
//  co    out  1  carry-out, active-low, combinational: co = ~(~ci & term)
//  tc    out  1  registered strobe, high one cycle after a terminal step
// BEHAVIOUR
//  - Reset (xr=0, async): q=RST_VAL, xq=~RST_VAL, tc=0; co follows ci/term.
//  - term = (dn==0) ? (q == all-ones) : (q == 0). Combinational from q and dn.
//  - Priority per rising edge of c: xr low > l > count > hold.
//  - l=1: q<=d next edge, regardless of ci/dn/wrap; tc<=0.
//  - l=0, ci=0, term=0: q<=q+1 (dn=0) or q-1 (dn=1), modulo 2^W; tc<=0.
//  - l=0, ci=0, term=1: q<=rv if wrap=1, else q wraps (all-ones->0 up,
//    0->all-ones down); tc<=1.
//  - l=0, ci=1: q holds; tc<=0.
//  - Latency: load and count take effect 1 edge later; tc rises 1 edge after
//    the terminal edge and lasts 1 cycle unless the next step is also terminal.
//  - Chaining: stage k ci = stage k-1 co; stage 0 ci = enable_n. co is
//    combinational so a chain counts as one wide counter in one cycle.
//  - dn or wrap may change any cycle; a change is used at the next edge only.
//  - wrap=1 with rv == terminal value: q sticks at terminal, tc high every
//    counting cycle. This is legal.
//  - xr asserted mid-count: immediate reset. Count resumes on the first edge
//    with xr=1. No state survives reset.
// CONFIGURATION
//  CBX_PRESET_EN defined: adds port xs (in, 1, async set, active-low).
//    xs=0 forces q=all-ones, tc=0 asynchronously. xr has priority over xs.
//    Release is synchronous to the next c edge, same as xr.
//  CBX_PRESET_EN undefined: no xs port; only xr initialises state.
// TESTING
//  1 xr=0 while c toggles, W=8, RST_VAL=0 -> q=0x00, xq=0xFF, tc=0;
//    co=1 with ci=1, co=0 with ci=0, dn=1.
//  2 l=1, d=0xFD, then ci=0, dn=0, wrap=0 for 4 edges -> q=FE,FF,00,01;
//    co=0 only while q=FF; tc=1 the cycle q=00.
//  3 dn=1, wrap=1, rv=0x05, load 0x02, ci=0 -> q=01,00,05,04; tc pulses
//    once, the cycle after q=00 goes to 05.
//  4 ci=0 and l=1 same edge, d=0x40, q=0x3F -> q=0x40 (load wins); tc=0.
//  5 Two W=4 instances chained (co->ci), load 0x0F/0x0E, enable -> 8-bit value
//    0xEF->0xF0 in one edge; xr pulse mid-count -> both 0 asynchronously.
//  6 [CBX_PRESET_EN] xs=0 -> q=0xFF; xs=0 and xr=0 together -> q=0x00.

Source files
------------

// File: rtl/cbx_counter.sv
`default_nettype none
// ============================================================================
//  Module   : cbx_counter
//  Brief    : Parametrised loadable up/down counter with an active-low
//             carry-in/carry-out chain, terminal-count auto-reload and a
//             registered terminal-count strobe.
//  Options  : CBX_PRESET_EN adds xs, an asynchronous active-low preset that
//             forces q to all-ones. xr has priority over xs.
//  Revision : 1.0  initial release
// ============================================================================
module cbx_counter #(
  parameter int             W       = 8,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         c,
  input  logic         xr,
`ifdef CBX_PRESET_EN
  input  logic         xs,
`endif
  input  logic         l,
  input  logic [W-1:0] d,
  input  logic         ci,
  input  logic         dn,
  input  logic         wrap,
  input  logic [W-1:0] rv,
  output logic [W-1:0] q,
  output logic [W-1:0] xq,
  output logic         co,
  output logic         tc
);

  localparam logic [W-1:0] C_ALL_ONES = '1;

  logic [W-1:0] cnt_q, cnt_d;
  logic         tc_q, tc_d;
  logic         term;

  // Terminal value depends on direction: all-ones counting up, zero counting down.
  always_comb begin
    term = dn ? (cnt_q == '0) : (cnt_q == C_ALL_ONES);
  end

  // Carry-out is combinational so a chain of stages steps as one wide counter.
  assign co = ~(~ci & term);
  assign q  = cnt_q;
  assign xq = ~cnt_q;
  assign tc = tc_q;

  // Next-state: load beats count beats hold; tc only follows a terminal step.
  always_comb begin
    cnt_d = cnt_q;
    tc_d  = 1'b0;
    if (l) begin
      cnt_d = d;
    end else if (!ci) begin
      if (term) begin
        tc_d  = 1'b1;
        cnt_d = wrap ? rv : (dn ? C_ALL_ONES : '0);
      end else begin
        cnt_d = dn ? (cnt_q - 1'b1) : (cnt_q + 1'b1);
      end
    end
  end

`ifdef CBX_PRESET_EN
  // State register with asynchronous reset (dominant) and asynchronous preset.
  always_ff @(posedge c or negedge xr or negedge xs) begin
    if (!xr) begin
      cnt_q <= RST_VAL;
      tc_q  <= 1'b0;
    end else if (!xs) begin
      cnt_q <= C_ALL_ONES;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
    end
  end
`else
  // State register with asynchronous reset.
  always_ff @(posedge c or negedge xr) begin
    if (!xr) begin
      cnt_q <= RST_VAL;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cbx_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cbx_counter
//  Brief    : Directed and randomized checks of cbx_counter against an
//             arithmetic reference model; also checks a two-stage W=4 chain.
//  Options  : CBX_PRESET_EN enables the preset checks.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cbx_counter;

  logic       c = 1'b0;
  logic       xr = 1'b0;
  logic       l = 1'b0;
  logic [7:0] d = '0;
  logic       ci = 1'b1;
  logic       dn = 1'b0;
  logic       wrap = 1'b0;
  logic [7:0] rv = '0;
  logic [7:0] q, xq;
  logic       co, tc;
`ifdef CBX_PRESET_EN
  logic       xs = 1'b1;
`endif

  // Chain of two 4-bit stages.
  logic       l_ch = 1'b0;
  logic [3:0] d_lo = '0, d_hi = '0;
  logic       en_n = 1'b1;
  logic [3:0] q_lo, q_hi, xq_lo, xq_hi;
  logic       co_lo, co_hi, tc_lo, tc_hi;

  int tests = 0;
  int fails = 0;

  // Reference model state.
  int m_q  = 0;
  int m_tc = 0;

  always #5 c = ~c;

  cbx_counter #(.W(8), .RST_VAL(8'h00)) u_dut (
    .c(c), .xr(xr),
`ifdef CBX_PRESET_EN
    .xs(xs),
`endif
    .l(l), .d(d), .ci(ci), .dn(dn), .wrap(wrap), .rv(rv),
    .q(q), .xq(xq), .co(co), .tc(tc)
  );

  cbx_counter #(.W(4), .RST_VAL(4'h0)) u_lo (
    .c(c), .xr(xr),
`ifdef CBX_PRESET_EN
    .xs(1'b1),
`endif
    .l(l_ch), .d(d_lo), .ci(en_n), .dn(1'b0), .wrap(1'b0), .rv(4'h0),
    .q(q_lo), .xq(xq_lo), .co(co_lo), .tc(tc_lo)
  );

  cbx_counter #(.W(4), .RST_VAL(4'h0)) u_hi (
    .c(c), .xr(xr),
`ifdef CBX_PRESET_EN
    .xs(1'b1),
`endif
    .l(l_ch), .d(d_hi), .ci(co_lo), .dn(1'b0), .wrap(1'b0), .rv(4'h0),
    .q(q_hi), .xq(xq_hi), .co(co_hi), .tc(tc_hi)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Terminal condition straight from the rule: top of range up, bottom down.
  function automatic int m_term();
    return (dn ? (m_q == 0) : (m_q == 255)) ? 1 : 0;
  endfunction

  // Advance the model by one rising edge using the current inputs.
  task automatic model_edge();
    if (!xr) begin
      m_q = 0; m_tc = 0;
    end else if (l) begin
      m_q = int'(d); m_tc = 0;
    end else if (!ci) begin
      if (m_term() == 1) begin
        m_tc = 1;
        m_q  = wrap ? int'(rv) : (dn ? 255 : 0);
      end else begin
        m_tc = 0;
        m_q  = dn ? (m_q + 255) % 256 : (m_q + 1) % 256;
      end
    end else begin
      m_tc = 0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".q"},  int'(q),  m_q);
    chk({tag, ".xq"}, int'(xq), 255 - m_q);
    chk({tag, ".tc"}, int'(tc), m_tc);
    chk({tag, ".co"}, int'(co), (!ci && m_term() == 1) ? 0 : 1);
  endtask

  // One edge: update model, take the edge, sample 1 time unit later.
  task automatic tick(input string tag);
    model_edge();
    @(posedge c);
    #1;
    check_all(tag);
  endtask

  initial begin
    // 1: reset held while the clock runs.
    xr = 1'b0; ci = 1'b1; dn = 1'b0;
    repeat (3) @(posedge c);
    #1;
    m_q = 0; m_tc = 0;
    check_all("rst");
    ci = 1'b0; dn = 1'b1; #1;
    chk("rst.co_dn", int'(co), 0);
    ci = 1'b1; dn = 1'b0;
    @(negedge c);
    xr = 1'b1;

    // 2: load FD then count up through the wrap.
    l = 1'b1; d = 8'hFD; tick("ld_fd");
    l = 1'b0; ci = 1'b0; dn = 1'b0; wrap = 1'b0;
    tick("up_fe");
    chk("up_fe.const", int'(q), 8'hFE);
    tick("up_ff");
    chk("up_ff.co", int'(co), 0);
    tick("up_00");
    chk("up_00.tc", int'(tc), 1);
    tick("up_01");
    chk("up_01.q", int'(q), 8'h01);

    // 3: down with reload of 05.
    l = 1'b1; d = 8'h02; dn = 1'b1; wrap = 1'b1; rv = 8'h05; tick("ld_02");
    l = 1'b0;
    tick("dn_01");
    tick("dn_00");
    tick("dn_05");
    chk("dn_05.tc", int'(tc), 1);
    tick("dn_04");
    chk("dn_04.q", int'(q), 8'h04);
    chk("dn_04.tc", int'(tc), 0);

    // 4: load wins over count.
    dn = 1'b0; wrap = 1'b0;
    l = 1'b1; d = 8'h3F; tick("ld_3f");
    l = 1'b1; d = 8'h40; ci = 1'b0; tick("ld_40");
    chk("ld_40.q", int'(q), 8'h40);
    l = 1'b0;

    // 5: chained 4-bit stages act as one 8-bit counter.
    ci = 1'b1;
    l_ch = 1'b1; d_lo = 4'hF; d_hi = 4'hE; en_n = 1'b1;
    tick("ch_ld");
    chk("ch_ld.val", int'({q_hi, q_lo}), 8'hEF);
    l_ch = 1'b0; en_n = 1'b0;
    tick("ch_step");
    chk("ch_step.val", int'({q_hi, q_lo}), 8'hF0);
    tick("ch_step2");
    chk("ch_step2.val", int'({q_hi, q_lo}), 8'hF1);
    #2;
    xr = 1'b0; #1;
    m_q = 0; m_tc = 0;
    chk("ch_rst.val", int'({q_hi, q_lo}), 8'h00);
    check_all("ch_rst");
    @(negedge c);
    xr = 1'b1; en_n = 1'b1;

`ifdef CBX_PRESET_EN
    // 6: preset forces all-ones; reset dominates.
    xs = 1'b0; #1;
    chk("ps.q", int'(q), 8'hFF);
    chk("ps.tc", int'(tc), 0);
    xr = 1'b0; #1;
    chk("ps_rst.q", int'(q), 8'h00);
    xr = 1'b1; #1;
    chk("ps_rel.q", int'(q), 8'hFF);
    @(negedge c);
    xs = 1'b1;
    m_q = 255; m_tc = 0;
`endif

    // Randomized run against the model.
    for (int i = 0; i < 400; i++) begin
      @(negedge c);
      l    = ($urandom_range(0, 15) == 0);
      d    = 8'($urandom);
      ci   = ($urandom_range(0, 3) == 0);
      dn   = 1'($urandom);
      wrap = 1'($urandom);
      rv   = ($urandom_range(0, 7) == 0) ? (dn ? 8'h00 : 8'hFF) : 8'($urandom);
      // Bias towards terminal values so reloads and tc get exercised.
      if ($urandom_range(0, 5) == 0) begin
        l = 1'b1;
        d = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
      end
      tick("rnd");
      if ($urandom_range(0, 40) == 0) begin
        #1;
        xr = 1'b0; #1;
        m_q = 0; m_tc = 0;
        check_all("rnd_rst");
        xr = 1'b1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
